// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: branch-type encodings, NOP word and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JUMP = 2'd1,
        BR_JR   = 2'd2,
        BR_COND = 2'd3
    } branch_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_target_calc.sv
// Redirect target for the instruction currently in ID, selected by its BranchType.
module branch_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] PCPlus4,
    input  logic [15:0] BranchOffset,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrAddr,
    input  logic [1:0]  BranchType,
    output logic [31:0] Target
);

    logic [31:0] branchDisp;

    assign branchDisp = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};

    always_comb begin
        Target = PCPlus4 + 32'd4;
        case (BranchType)
            BR_JUMP: Target = {PCPlus4[31:28], JumpIndex, 2'b00};
            // jr targets are word aligned regardless of the low bits of rs
            BR_JR:   Target = JrAddr & 32'hFFFF_FFFC;
            BR_COND: Target = PCPlus4 + branchDisp;
            default: Target = PCPlus4 + 32'd4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, asynchronous-read IMEM interface, IF/ID register and a fetch counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    output logic [IMEM_AW-1:0] IMemAddr,
    input  logic [31:0]        IMemData,
    input  logic               Stall,
    input  logic [1:0]         BranchType,
    input  logic               BranchTaken,
    input  logic [15:0]        BranchOffset,
    input  logic [25:0]        JumpIndex,
    input  logic [31:0]        JrAddr,
    output logic [31:0]        PC,
    output logic [31:0]        Instruction,
    output logic [31:0]        PCPlus4,
    output logic               Valid,
    output logic [31:0]        InstCount
);

    logic [31:0] target;
    logic [31:0] seqPC;
    logic        redirect;

    branch_target_calc uTarget (
        .PCPlus4      (PCPlus4),
        .BranchOffset (BranchOffset),
        .JumpIndex    (JumpIndex),
        .JrAddr       (JrAddr),
        .BranchType   (BranchType),
        .Target       (target)
    );

    assign IMemAddr = PC[IMEM_AW+1:2];
    assign seqPC    = PC + 32'd4;

    // A squashed bubble carries Valid=0, so back-to-back redirects cannot happen.
    assign redirect = Valid & ~Stall &
                      ((BranchType == BR_JUMP) | (BranchType == BR_JR) |
                       ((BranchType == BR_COND) & BranchTaken));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC          <= RESET_PC;
            Instruction <= NOP_INSTR;
            PCPlus4     <= RESET_PC;
            Valid       <= 1'b0;
            InstCount   <= 32'd0;
        end else if (!Stall) begin
            PCPlus4 <= seqPC;
            if (redirect) begin
                PC          <= target;
                Instruction <= NOP_INSTR;
                Valid       <= 1'b0;
            end else begin
                PC          <= seqPC;
                Instruction <= IMemData;
                Valid       <= 1'b1;
                InstCount   <= InstCount + 32'd1;
            end
        end
    end

endmodule
